// File: rtl/video_pkg.sv
// video_pkg: default raster timing and pixel coordinate types shared by video consumers
package video_pkg;
   localparam int CLK_DIV_D   = 2;
   localparam int H_VISIBLE_D = 256;
   localparam int H_FRONT_D   = 16;
   localparam int H_SYNC_D    = 32;
   localparam int H_BACK_D    = 48;
   localparam int V_VISIBLE_D = 128;
   localparam int V_FRONT_D   = 4;
   localparam int V_SYNC_D    = 4;
   localparam int V_BACK_D    = 24;
   localparam bit SYNC_POL_D  = 1'b1;
   typedef logic [7:0] hpos_t;
   typedef logic [6:0] vpos_t;
endpackage

// File: rtl/video_timing_wrap_counter.sv
// wrap_counter: modulo-MAX counter advancing on en; wrap flags the enabled last count
module wrap_counter #(
   parameter int MAX = 2,
   localparam int W = MAX > 1 ? $clog2(MAX) : 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);
   localparam logic [W-1:0] LAST = W'(MAX - 1);
   assign wrap = en && count == LAST;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) count <= '0;
      else if (en) count <= wrap ? '0 : count + W'(1);
endmodule

// File: rtl/video_timing.sv
// video_timing: pixel divider, h/v raster counters and registered sync/position outputs
module video_timing
   import video_pkg::*;
#(
   parameter int CLK_DIV   = CLK_DIV_D,
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FRONT   = H_FRONT_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BACK    = H_BACK_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FRONT   = V_FRONT_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BACK    = V_BACK_D,
   parameter bit SYNC_POL  = SYNC_POL_D
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       run,
   output hpos_t      hpos,
   output vpos_t      vpos,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       pix_en,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_count
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int WD = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam int WH = $clog2(H_TOTAL);
   localparam int WV = $clog2(V_TOTAL);
   localparam logic [WH-1:0] H_VIS = WH'(H_VISIBLE);
   localparam logic [WH-1:0] HS_ON = WH'(H_VISIBLE + H_FRONT);
   localparam logic [WH-1:0] HS_OFF = WH'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [WV-1:0] V_VIS = WV'(V_VISIBLE);
   localparam logic [WV-1:0] VS_ON = WV'(V_VISIBLE + V_FRONT);
   localparam logic [WV-1:0] VS_OFF = WV'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam bit PARAMS_OK = H_VISIBLE >= 1 && H_VISIBLE <= 256 && V_VISIBLE >= 1 && V_VISIBLE <= 128
      && CLK_DIV >= 1 && H_FRONT >= 1 && H_SYNC >= 1 && H_BACK >= 1
      && V_FRONT >= 1 && V_SYNC >= 1 && V_BACK >= 1;
   if (!PARAMS_OK) begin : g_bad_params
      $error("video_timing: illegal timing parameters");
   end
   logic [WD-1:0] unused_div;
   logic [WH-1:0] hcnt, h_nxt;
   logic [WV-1:0] vcnt, v_nxt;
   logic          tick, h_wrap, v_wrap;
   wrap_counter #(.MAX(CLK_DIV)) u_div (
      .clk(clk), .reset_n(reset_n), .en(run), .count(unused_div), .wrap(tick)
   );
   wrap_counter #(.MAX(H_TOTAL)) u_hcnt (
      .clk(clk), .reset_n(reset_n), .en(tick), .count(hcnt), .wrap(h_wrap)
   );
   wrap_counter #(.MAX(V_TOTAL)) u_vcnt (
      .clk(clk), .reset_n(reset_n), .en(h_wrap), .count(vcnt), .wrap(v_wrap)
   );
   // outputs describe the position the counters move to on this tick
   assign h_nxt = h_wrap ? '0 : hcnt + WH'(1);
   assign v_nxt = v_wrap ? '0 : h_wrap ? vcnt + WV'(1) : vcnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         hpos        <= '0;
         vpos        <= '0;
         hsync       <= !SYNC_POL;
         vsync       <= !SYNC_POL;
         display_on  <= 1'b0;
         pix_en      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_count <= '0;
      end else begin
         pix_en      <= tick;
         line_start  <= h_wrap;
         frame_start <= v_wrap;
         if (v_wrap) frame_count <= frame_count + 8'd1;
         if (tick) begin
            hpos       <= h_nxt < H_VIS ? hpos_t'(h_nxt) : '0;
            vpos       <= v_nxt < V_VIS ? vpos_t'(v_nxt) : '0;
            hsync      <= (h_nxt >= HS_ON && h_nxt < HS_OFF) ? SYNC_POL : !SYNC_POL;
            vsync      <= (v_nxt >= VS_ON && v_nxt < VS_OFF) ? SYNC_POL : !SYNC_POL;
            display_on <= h_nxt < H_VIS && v_nxt < V_VIS;
         end
      end
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: random-run scoreboard against a pixel-index model, plus directed timing checks
module tb_video_timing;
   typedef struct packed {
      logic [7:0] hpos;
      logic [6:0] vpos;
      logic       hsync;
      logic       vsync;
      logic       disp;
      logic [7:0] fc;
   } lv_t;
   localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2, B_VV = 4, B_VF = 1, B_VS = 2, B_VB = 1;
   localparam int B_HT = B_HV + B_HF + B_HS + B_HB, B_VT = B_VV + B_VF + B_VS + B_VB;
   logic clk = 0, rst_a = 0, run_a = 1, rst_b = 0, run_b = 1;
   logic [7:0] a_hpos, b_hpos, a_fc, b_fc;
   logic [6:0] a_vpos, b_vpos;
   logic a_hsync, a_vsync, a_disp, a_pix_en, a_ls, a_fs;
   logic b_hsync, b_vsync, b_disp, b_pix_en, b_ls, b_fs;
   int checks = 0, failures = 0;
   int ra = 0, na = 0, rb = 0, nb = 0;
   logic tka = 0, tkb = 0;
   always #5 clk = ~clk;
   video_timing u_a (
      .clk(clk), .reset_n(rst_a), .run(run_a), .hpos(a_hpos), .vpos(a_vpos), .hsync(a_hsync),
      .vsync(a_vsync), .display_on(a_disp), .pix_en(a_pix_en), .line_start(a_ls),
      .frame_start(a_fs), .frame_count(a_fc)
   );
   video_timing #(
      .CLK_DIV(1), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
      .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .SYNC_POL(1'b0)
   ) u_b (
      .clk(clk), .reset_n(rst_b), .run(run_b), .hpos(b_hpos), .vpos(b_vpos), .hsync(b_hsync),
      .vsync(b_vsync), .display_on(b_disp), .pix_en(b_pix_en), .line_start(b_ls),
      .frame_start(b_fs), .frame_count(b_fc)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   // expected level outputs after n pixel ticks since reset (n==0: reset values)
   function automatic lv_t model(input int n, input int hv, hf, hs, ht, vv, vf, vs, vt, input bit pol);
      lv_t r;
      int h, v;
      h = n % ht;
      v = (n / ht) % vt;
      r = '0;
      r.hsync = !pol;
      r.vsync = !pol;
      if (n > 0) begin
         r.hpos  = h < hv ? 8'(h) : 8'd0;
         r.vpos  = v < vv ? 7'(v) : 7'd0;
         r.hsync = (h >= hv + hf && h < hv + hf + hs) ? pol : !pol;
         r.vsync = (v >= vv + vf && v < vv + vf + vs) ? pol : !pol;
         r.disp  = h < hv && v < vv;
         r.fc    = 8'(n / (ht * vt));
      end
      return r;
   endfunction
   always begin
      @(posedge clk);
      if (!rst_a) begin ra = 0; na = 0; tka = 0; end
      else if (run_a) begin ra++; tka = ra % 2 == 0; if (tka) na++; end
      else tka = 0;
      #1;
      check("a_levels", {a_hpos, a_vpos, a_hsync, a_vsync, a_disp, a_fc},
            model(na, 256, 16, 32, 352, 128, 4, 4, 160, 1'b1));
      check("a_pulses", {a_pix_en, a_ls, a_fs},
            {tka, tka && na % 352 == 0, tka && na % 56320 == 0});
   end
   always begin
      @(posedge clk);
      if (!rst_b) begin rb = 0; nb = 0; tkb = 0; end
      else if (run_b) begin rb++; tkb = 1; nb++; end
      else tkb = 0;
      #1;
      check("b_levels", {b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_fc},
            model(nb, B_HV, B_HF, B_HS, B_HT, B_VV, B_VF, B_VS, B_VT, 1'b0));
      check("b_pulses", {b_pix_en, b_ls, b_fs},
            {tkb, tkb && nb % B_HT == 0, tkb && nb % (B_HT * B_VT) == 0});
   end
   initial begin
      fork
         begin : thread_a
            int pe, hs, mx, hi;
            bit found;
            repeat (5) @(negedge clk);
            check("a_rst_hsync", a_hsync, 0);
            check("a_rst_pix_en", a_pix_en, 0);
            check("a_rst_hpos", a_hpos, 0);
            check("a_rst_disp", a_disp, 0);
            rst_a = 1;
            for (int i = 0; i < 1500; i++) begin
               @(negedge clk);
               run_a = $urandom_range(0, 15) != 0;
            end
            run_a = 1;
            found = 0;
            for (int i = 0; i < 2000 && !found; i++) begin @(negedge clk); found = a_ls; end
            check("a_line_start_seen", found, 1);
            pe = 0; hs = 0; mx = 0; found = 0;
            for (int i = 0; i < 2000 && !found; i++) begin
               @(negedge clk);
               if (a_pix_en) begin pe++; if (a_hsync) hs++; if (a_hpos > mx) mx = a_hpos; end
               found = a_ls;
            end
            check("a_line_len", pe, 352);
            check("a_hsync_width", hs, 32);
            check("a_hpos_max", mx, 255);
            found = 0;
            for (int i = 0; i < 1000 && !found; i++) begin @(negedge clk); found = a_pix_en && a_hpos == 100; end
            check("a_hpos100_seen", found, 1);
            run_a = 0;
            pe = 0;
            repeat (50) begin @(negedge clk); if (a_pix_en) pe++; end
            check("a_freeze_pix_en", pe, 0);
            check("a_freeze_hpos", a_hpos, 100);
            run_a = 1;
            for (int i = 0; i < 10 && !a_pix_en; i++) @(negedge clk);
            check("a_resume_pix_en", a_pix_en, 1);
            check("a_resume_hpos", a_hpos, 101);
            found = 0;
            for (int i = 0; i < 1000 && !found; i++) begin @(negedge clk); found = na % 352 == 280; end
            check("a_mid_hsync_seen", found, 1);
            check("a_mid_hsync_level", a_hsync, 1);
            #1 rst_a = 0;
            #1;
            check("a_async_hsync", a_hsync, 0);
            check("a_async_hpos", a_hpos, 0);
            check("a_async_pix_en", a_pix_en, 0);
            repeat (3) @(negedge clk);
            rst_a = 1;
            hi = 0; found = 0;
            for (int i = 0; i < 700 && !found; i++) begin
               @(negedge clk);
               found = na == 272;
               if (!found && a_hsync) hi++;
            end
            check("a_reach_272", found, 1);
            check("a_hsync_before_272", hi, 0);
            check("a_hsync_at_272", a_hsync, 1);
            repeat (100) @(negedge clk);
         end
         begin : thread_b
            int pe, fs;
            bit done;
            pe = 0; fs = 0; done = 0;
            repeat (4) @(negedge clk);
            check("b_rst_hsync", b_hsync, 1);
            check("b_rst_fc", b_fc, 0);
            rst_b = 1;
            for (int i = 0; i < 40000 && !done; i++) begin
               @(negedge clk);
               if (b_pix_en) pe++;
               if (b_fs) begin
                  if (fs > 0 && fs < 4) check("b_frame_len", pe, B_HT * B_VT);
                  pe = 0;
                  fs++;
                  if (b_fc == 0) begin check("b_wrap_frames", fs, 256); done = 1; end
               end
               run_b = $urandom_range(0, 15) != 0;
            end
            check("b_wrap_seen", done, 1);
            run_b = 1;
         end
      join
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
